seq_alu: RTL and testbench

Parametrised multicycle ALU for the MIPS datapath and its multicycle variants. Single-cycle logic/arithmetic ops return a registered result one cycle after issue. Multiply and unsigned divide run as iterative shift-add and restoring-divide loops under a start/done handshake. Adds signed compare, XOR, full-width product high half and remainder, plus a busy indication the control unit uses to stall.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/seq_alu_if.sv | 25 ++
 rtl/seq_muldiv_core.sv | 78 +++++++
 rtl/seq_alu.sv | 105 ++++++++++
 tb/tb_seq_alu.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and op-select width for the sequential ALU.
package alu_pkg;

    localparam int SEL_W = 4;

    localparam logic [SEL_W-1:0] OP_AND  = 4'b0000;
    localparam logic [SEL_W-1:0] OP_OR   = 4'b0001;
    localparam logic [SEL_W-1:0] OP_ADD  = 4'b0010;
    localparam logic [SEL_W-1:0] OP_XOR  = 4'b0011;
    localparam logic [SEL_W-1:0] OP_SUB  = 4'b0100;
    localparam logic [SEL_W-1:0] OP_MUL  = 4'b0101;
    localparam logic [SEL_W-1:0] OP_SLTU = 4'b0110;
    localparam logic [SEL_W-1:0] OP_SLT  = 4'b0111;
    localparam logic [SEL_W-1:0] OP_DIVU = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV
    } state_t;

    function automatic logic is_iterative(input logic [SEL_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Issue/result bundle between the control unit and the sequential ALU.
interface seq_alu_if #(
    parameter int WIDTH = 32,
    parameter int SEL   = alu_pkg::SEL_W
);
    logic             start;
    logic [SEL-1:0]   sel;
    logic [WIDTH-1:0] inp1;
    logic [WIDTH-1:0] inp2;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero_flag;
    logic             busy;
    logic             done;

    modport master (
        output start, sel, inp1, inp2,
        input  result, result_hi, zero_flag, busy, done
    );

    modport slave (
        input  start, sel, inp1, inp2,
        output result, result_hi, zero_flag, busy, done
    );
endinterface

// File: rtl/seq_muldiv_core.sv
// Iterative shift-add multiplier / restoring divider sharing one 2*WIDTH accumulator.
module seq_muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             fin,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_src, acc_nxt;
    logic [WIDTH-1:0]   opnd_q, opnd_src;
    logic               div_q, div_src, run_q;
    logic [CNT_W-1:0]   cnt_q;

    // Multiply: {hi, multiplier}; add multiplicand into hi when the LSB is set, then shift right.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                    input logic [WIDTH-1:0]   mcand);
        logic [WIDTH:0] sum;
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        return {sum, acc[WIDTH-1:1]};
    endfunction

    // Divide: {remainder, dividend/quotient}; shift left one bit and subtract when it fits.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                    input logic [WIDTH-1:0]   dvsr);
        logic [WIDTH:0]   part;
        logic [WIDTH-1:0] diff;
        part = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff = part[WIDTH-1:0] - dvsr;
        if (part >= {1'b0, dvsr})
            return {diff, acc[WIDTH-2:0], 1'b1};
        else
            return {part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    endfunction

    // The issue edge already performs the first iteration, so the op spans exactly WIDTH edges.
    always_comb begin
        acc_src  = go ? {{WIDTH{1'b0}}, (is_div ? op_a : op_b)} : acc_q;
        opnd_src = go ? (is_div ? op_b : op_a) : opnd_q;
        div_src  = go ? is_div : div_q;
        acc_nxt  = div_src ? div_step(acc_src, opnd_src) : mul_step(acc_src, opnd_src);
    end

    // cnt_q holds the iterations still to run after the current edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
            run_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (go) begin
            acc_q  <= acc_nxt;
            opnd_q <= opnd_src;
            div_q  <= is_div;
            run_q  <= 1'b1;
            cnt_q  <= CNT_W'(WIDTH - 1);
        end else if (run_q) begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1))
                run_q <= 1'b0;
        end
    end

    assign fin    = run_q && (cnt_q == CNT_W'(1));
    assign res_lo = acc_nxt[WIDTH-1:0];
    assign res_hi = acc_nxt[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/seq_alu.sv
// Multicycle ALU: registered single-cycle ops plus iterative MUL/DIVU behind a start/done handshake.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEL   = SEL_W
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);

    state_t           state;
    logic [SEL-1:0]   op;
    logic             go, is_div, fin;
    logic [WIDTH-1:0] core_lo, core_hi;
    logic [WIDTH-1:0] single_res;
    logic [WIDTH-1:0] result_q, result_hi_q;
    logic             zero_q, busy_q, done_q;

    function automatic logic [WIDTH-1:0] alu_single(input logic [SEL_W-1:0] code,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa, sb;
        sa = a;
        sb = b;
        case (code)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_XOR:  return a ^ b;
            OP_SUB:  return a - b;
            OP_SLTU: return {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLT:  return {{(WIDTH-1){1'b0}}, (sa < sb)};
            default: return '0;
        endcase
    endfunction

    assign op         = bus.sel;
    assign is_div     = (op == OP_DIVU);
    assign go         = bus.start && (state == ST_IDLE) && is_iterative(op);
    assign single_res = alu_single(op, bus.inp1, bus.inp2);

    seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .go     (go),
        .is_div (is_div),
        .op_a   (bus.inp1),
        .op_b   (bus.inp2),
        .fin    (fin),
        .res_lo (core_lo),
        .res_hi (core_hi)
    );

    // Outputs only move on a done edge; starts are ignored outside IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (op == OP_MUL) begin
                            state  <= ST_MUL;
                            busy_q <= 1'b1;
                        end else if (op == OP_DIVU) begin
                            state  <= ST_DIV;
                            busy_q <= 1'b1;
                        end else begin
                            result_q    <= single_res;
                            result_hi_q <= '0;
                            zero_q      <= (single_res == '0);
                            done_q      <= 1'b1;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (fin) begin
                        result_q    <= core_lo;
                        result_hi_q <= core_hi;
                        zero_q      <= (core_lo == '0);
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.zero_flag = zero_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomised and directed checks of seq_alu (WIDTH=32 and WIDTH=8) against an arithmetic reference model.
module tb_seq_alu;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(32)) b32 ();
    seq_alu_if #(.WIDTH(8))  b8 ();

    seq_alu #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    seq_alu #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] get_res(input bit w8);
        return w8 ? {24'h0, b8.result} : b32.result;
    endfunction
    function automatic logic [31:0] get_hi(input bit w8);
        return w8 ? {24'h0, b8.result_hi} : b32.result_hi;
    endfunction
    function automatic logic get_zero(input bit w8);
        return w8 ? b8.zero_flag : b32.zero_flag;
    endfunction
    function automatic logic get_busy(input bit w8);
        return w8 ? b8.busy : b32.busy;
    endfunction
    function automatic logic get_done(input bit w8);
        return w8 ? b8.done : b32.done;
    endfunction

    task automatic drive(input bit w8, input bit st, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            b8.start = st; b8.sel = op; b8.inp1 = a[7:0]; b8.inp2 = b[7:0];
        end else begin
            b32.start = st; b32.sel = op; b32.inp1 = a; b32.inp2 = b;
        end
    endtask

    // Reference: what each op means arithmetically, with latency in cycles.
    task automatic ref_op(input bit w8, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] r,
                          output logic [31:0] hi, output int lat);
        int          w;
        logic [63:0] m, ua, ub, p;
        longint      sa, sb;
        w  = w8 ? 8 : 32;
        m  = w8 ? 64'hff : 64'hffff_ffff;
        ua = {32'h0, a} & m;
        ub = {32'h0, b} & m;
        if (w8) begin
            sa = $signed(a[7:0]);
            sb = $signed(b[7:0]);
        end else begin
            sa = $signed(a);
            sb = $signed(b);
        end
        p   = 64'h0;
        hi  = 32'h0;
        lat = 1;
        case (op)
            4'd0: p = ua & ub;
            4'd1: p = ua | ub;
            4'd2: p = ua + ub;
            4'd3: p = ua ^ ub;
            4'd4: p = ua - ub;
            4'd5: begin
                p   = ua * ub;
                hi  = 32'((p >> w) & m);
                lat = w;
            end
            4'd6: p = (ua < ub) ? 64'd1 : 64'd0;
            4'd7: p = (sa < sb) ? 64'd1 : 64'd0;
            4'd8: begin
                lat = w;
                if (ub == 64'h0) begin
                    p  = m;
                    hi = 32'(ua);
                end else begin
                    p  = ua / ub;
                    hi = 32'(ua % ub);
                end
            end
            default: p = 64'h0;
        endcase
        r = 32'(p & m);
    endtask

    task automatic chk_reset(input string tag, input bit w8);
        chk({tag, " result"}, 64'(get_res(w8)), 64'h0);
        chk({tag, " result_hi"}, 64'(get_hi(w8)), 64'h0);
        chk({tag, " zero_flag"}, 64'(get_zero(w8)), 64'h1);
        chk({tag, " busy"}, 64'(get_busy(w8)), 64'h0);
        chk({tag, " done"}, 64'(get_done(w8)), 64'h0);
    endtask

    // Issue one op, wait (bounded) for done, and check latency, busy and results.
    task automatic run_op(input string tag, input bit w8, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input bit disturb);
        logic [31:0] r, hi;
        int          lat, cyc;
        bit          busy_ok;
        ref_op(w8, op, a, b, r, hi, lat);
        @(negedge clk);
        drive(w8, 1'b1, op, a, b);
        @(negedge clk);
        drive(w8, 1'b0, op, a, b);
        cyc     = 1;
        busy_ok = 1'b1;
        while (!get_done(w8) && cyc < 80) begin
            if (!get_busy(w8)) busy_ok = 1'b0;
            if (disturb && cyc == 5) drive(w8, 1'b1, 4'd2, $urandom, $urandom);
            else if (disturb && cyc == 6) drive(w8, 1'b0, 4'd4, $urandom, $urandom);
            @(negedge clk);
            cyc++;
        end
        chk({tag, " latency"}, 64'(cyc), 64'(lat));
        chk({tag, " result"}, 64'(get_res(w8)), 64'(r));
        chk({tag, " result_hi"}, 64'(get_hi(w8)), 64'(hi));
        chk({tag, " zero_flag"}, 64'(get_zero(w8)), 64'(r == 32'h0));
        chk({tag, " busy at done"}, 64'(get_busy(w8)), 64'h0);
        if (lat > 1) chk({tag, " busy during op"}, 64'(busy_ok), 64'h1);
        if (disturb) begin
            repeat (3) @(negedge clk);
            chk({tag, " no extra done"}, 64'(get_done(w8)), 64'h0);
            chk({tag, " result held"}, 64'(get_res(w8)), 64'(r));
        end
    endtask

    initial begin
        int seen;
        drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 4'd0, 32'h0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk_reset("reset32", 1'b0);
        chk_reset("reset8", 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_op("add wrap", 1'b0, 4'd2, 32'hffff_ffff, 32'h1, 1'b0);
        run_op("sub neg", 1'b0, 4'd4, 32'd5, 32'd7, 1'b0);
        repeat (3) @(negedge clk);
        chk("sub held", 64'(b32.result), 64'hffff_fffe);

        // SLT, SLTU, XOR issued on consecutive cycles.
        @(negedge clk);
        drive(1'b0, 1'b1, 4'd7, 32'hffff_ffff, 32'h1);
        @(negedge clk);
        chk("b2b slt done", 64'(b32.done), 64'h1);
        chk("b2b slt result", 64'(b32.result), 64'h1);
        drive(1'b0, 1'b1, 4'd6, 32'hffff_ffff, 32'h1);
        @(negedge clk);
        chk("b2b sltu done", 64'(b32.done), 64'h1);
        chk("b2b sltu result", 64'(b32.result), 64'h0);
        drive(1'b0, 1'b1, 4'd3, 32'h0000_f0f0, 32'h0000_ffff);
        @(negedge clk);
        chk("b2b xor done", 64'(b32.done), 64'h1);
        chk("b2b xor result", 64'(b32.result), 64'h0f0f);
        drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("b2b done falls", 64'(b32.done), 64'h0);

        run_op("mul max", 1'b0, 4'd5, 32'hffff_ffff, 32'hffff_ffff, 1'b0);
        chk("mul max lo", 64'(b32.result), 64'h1);
        chk("mul max hi", 64'(b32.result_hi), 64'hffff_fffe);
        run_op("divu 100/7", 1'b0, 4'd8, 32'd100, 32'd7, 1'b1);
        run_op("divu 9/0", 1'b0, 4'd8, 32'd9, 32'd0, 1'b0);

        // Abort a MUL at iteration 10.
        @(negedge clk);
        drive(1'b0, 1'b1, 4'd5, 32'h1234_5678, 32'h9abc_def1);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd5, 32'h1234_5678, 32'h9abc_def1);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset("abort", 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (b32.done) seen++;
        end
        chk("abort no done", 64'(seen), 64'h0);
        run_op("add after abort", 1'b0, 4'd2, 32'd2, 32'd3, 1'b0);

        run_op("w8 mul max", 1'b1, 4'd5, 32'hff, 32'hff, 1'b0);
        chk("w8 mul lo", 64'(b8.result), 64'h01);
        chk("w8 mul hi", 64'(b8.result_hi), 64'hfe);
        run_op("w8 undef op", 1'b1, 4'd15, 32'h5a, 32'h3c, 1'b0);
        run_op("w8 divu 0", 1'b1, 4'd8, 32'hc3, 32'h0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            bit          w8;
            logic [3:0]  op;
            logic [31:0] a, b;
            w8 = ($urandom_range(0, 3) == 0);
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 9));
            if ($urandom_range(0, 5) == 0) a = b;
            run_op($sformatf("rand%0d op%0d", i, op), w8, op, a, b, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
